// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-mode LED pattern engine (count, scan, blink, PWM breathe)
module led_pattern_gen #(
    parameter int NUM_LEDS        = 4,
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int TICK_HZ         = 1000,
    parameter int BASE_STEP_TICKS = 500,
    parameter int PWM_BITS        = 8
) (
    input  logic                clk_50mhz,
    input  logic                rst_n,
    input  logic [1:0]          mode_sel,
    input  logic [1:0]          rate_sel,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_stb
);
    typedef enum logic [1:0] {M_COUNT, M_SCAN, M_BLINK, M_BREATHE} mode_t;

    localparam int PRESC_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int PW  = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int SW  = (BASE_STEP_TICKS > 1) ? $clog2(BASE_STEP_TICKS) : 1;
    localparam int SW1 = SW + 1;

    localparam logic [PW-1:0]       PRESC_TC = PW'(PRESC_MAX);
    localparam logic [SW:0]         BASE_V   = SW1'(BASE_STEP_TICKS);
    localparam logic [SW:0]         ONE_S    = SW1'(1);
    localparam logic [PWM_BITS-1:0] DUTY_TOP = '1;
    localparam logic [PWM_BITS-1:0] DUTY_PEN = DUTY_TOP - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

    mode_t               mode_q;
    logic [PW-1:0]       presc;
    logic [SW-1:0]       step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                breathe_up;
    logic                scan_up;
    logic [SW:0]         period;
    logic [SW:0]         term;
    logic                tick;
    logic                step;

    // A shifted-out period of zero still has to step, so it is clamped to one tick.
    always_comb begin
        period = BASE_V >> rate_sel;
        if (period == '0)
            period = ONE_S;
        term = period - ONE_S;
        tick = (presc == PRESC_TC);
        step = tick && ({1'b0, step_cnt} == term);
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= M_COUNT;
            presc      <= '0;
            step_cnt   <= '0;
            pwm_cnt    <= '0;
            duty       <= '0;
            breathe_up <= 1'b1;
            scan_up    <= 1'b1;
            led        <= '0;
            step_stb   <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            if (!pause) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (mode_sel != mode_q) begin
                    mode_q     <= mode_t'(mode_sel);
                    presc      <= '0;
                    step_cnt   <= '0;
                    duty       <= '0;
                    breathe_up <= 1'b1;
                    scan_up    <= 1'b1;
                    led        <= (mode_t'(mode_sel) == M_SCAN) ? LED_ONE : '0;
                end else begin
                    presc <= tick ? '0 : presc + PW'(1);
                    // Counter beyond a freshly shortened terminal wraps silently.
                    if (tick)
                        step_cnt <= ({1'b0, step_cnt} >= term) ? '0 : step_cnt + SW'(1);

                    if (mode_q == M_BREATHE) begin
                        led <= {NUM_LEDS{pwm_cnt < duty}};
                        if (tick) begin
                            if (breathe_up) begin
                                duty <= duty + DUTY_ONE;
                                if (duty == DUTY_PEN) begin
                                    breathe_up <= 1'b0;
                                    step_stb   <= 1'b1;
                                end
                            end else begin
                                duty <= duty - DUTY_ONE;
                                if (duty == DUTY_ONE) begin
                                    breathe_up <= 1'b1;
                                    step_stb   <= 1'b1;
                                end
                            end
                        end
                    end else if (step) begin
                        step_stb <= 1'b1;
                        case (mode_q)
                            M_COUNT: led <= led + LED_ONE;
                            M_BLINK: led <= ~led;
                            default: begin
                                if (NUM_LEDS == 1) begin
                                    led <= LED_ONE;
                                end else if (scan_up) begin
                                    if (led[NUM_LEDS-1]) begin
                                        led     <= led >> 1;
                                        scan_up <= 1'b0;
                                    end else begin
                                        led <= led << 1;
                                    end
                                end else begin
                                    if (led[0]) begin
                                        led     <= led << 1;
                                        scan_up <= 1'b1;
                                    end else begin
                                        led <= led >> 1;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;
    logic       clk_50mhz = 1'b0;
    logic       rst_n;
    logic [1:0] mode_sel;
    logic [1:0] rate_sel;
    logic       pause;
    logic [3:0] led;
    logic       step_stb;

    int checks = 0;
    int fails  = 0;

    led_pattern_gen #(
        .NUM_LEDS(4), .CLK_FREQ_HZ(1000), .TICK_HZ(100),
        .BASE_STEP_TICKS(4), .PWM_BITS(3)
    ) dut (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .mode_sel(mode_sel),
        .rate_sel(rate_sel), .pause(pause), .led(led), .step_stb(step_stb)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic wait_step(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_50mhz);
            cycles++;
        end while (!step_stb && cycles < limit);
        if (!step_stb) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode_sel = 2'd0; rate_sel = 2'd0; pause = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        checks++; if (led !== 4'h0) begin fails++; $display("FAIL reset_led: got %h expected 0", led); end
        checks++; if (step_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b expected 0", step_stb); end
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        int cyc;
        logic [3:0] exp_led;
        for (int i = 1; i <= 16; i++) begin
            wait_step(100, cyc);
            exp_led = 4'(i);
            checks++; if (cyc !== 40) begin fails++; $display("FAIL count_interval step %0d: got %0d cycles expected 40", i, cyc); end
            checks++; if (led !== exp_led) begin fails++; $display("FAIL count_led step %0d: got %h expected %h", i, led, exp_led); end
        end
        @(negedge clk_50mhz);
        checks++; if (step_stb !== 1'b0) begin fails++; $display("FAIL count_stb_width: got %b expected 0", step_stb); end
    endtask

    task automatic test_pause();
        int cyc;
        int guard = 0;
        logic bad = 1'b0;
        do begin
            wait_step(100, cyc);
            guard++;
        end while (led !== 4'h5 && guard < 10);
        repeat (15) @(negedge clk_50mhz);
        pause = 1'b1;
        repeat (100) begin
            @(negedge clk_50mhz);
            if (led !== 4'h5 || step_stb !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin fails++; $display("FAIL pause_hold: led=%h stb=%b expected led 5 and no strobe", led, step_stb); end
        pause = 1'b0;
        wait_step(100, cyc);
        checks++; if (cyc !== 25) begin fails++; $display("FAIL pause_resume_interval: got %0d cycles expected 25", cyc); end
        checks++; if (led !== 4'h6) begin fails++; $display("FAIL pause_resume_led: got %h expected 6", led); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_seq [0:6];
        logic onehot_bad = 1'b0;
        logic early_bad = 1'b0;
        exp_seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        mode_sel = 2'd1; rate_sel = 2'd1;
        @(negedge clk_50mhz);
        checks++; if (led !== 4'h1) begin fails++; $display("FAIL mode_change_led: got %h expected 1", led); end
        checks++; if (step_stb !== 1'b0) begin fails++; $display("FAIL mode_change_stb: got %b expected 0", step_stb); end
        for (int s = 0; s < 7; s++) begin
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk_50mhz);
                if (!$onehot(led)) onehot_bad = 1'b1;
                if (c < 20 && step_stb) early_bad = 1'b1;
            end
            checks++; if (step_stb !== 1'b1) begin fails++; $display("FAIL scan_stb step %0d: got %b expected 1", s, step_stb); end
            checks++; if (led !== exp_seq[s]) begin fails++; $display("FAIL scan_led step %0d: got %h expected %h", s, led, exp_seq[s]); end
        end
        checks++; if (onehot_bad) begin fails++; $display("FAIL scan_onehot: got non-one-hot led expected one-hot"); end
        checks++; if (early_bad) begin fails++; $display("FAIL scan_interval: got early strobe expected 20-cycle period"); end
    endtask

    task automatic test_async_reset();
        int cyc;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (led !== 4'h0) begin fails++; $display("FAIL async_reset_led: got %h expected 0", led); end
        checks++; if (step_stb !== 1'b0) begin fails++; $display("FAIL async_reset_stb: got %b expected 0", step_stb); end
        mode_sel = 2'd0; rate_sel = 2'd0;
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        wait_step(100, cyc);
        checks++; if (cyc !== 40) begin fails++; $display("FAIL restart_interval: got %0d cycles expected 40", cyc); end
        checks++; if (led !== 4'h1) begin fails++; $display("FAIL restart_led: got %h expected 1", led); end
    endtask

    task automatic test_blink();
        int cyc;
        logic [3:0] exp_led;
        mode_sel = 2'd2; rate_sel = 2'd3;
        @(negedge clk_50mhz);
        checks++; if (led !== 4'h0) begin fails++; $display("FAIL blink_init: got %h expected 0", led); end
        exp_led = 4'h0;
        for (int i = 0; i < 4; i++) begin
            wait_step(50, cyc);
            exp_led = ~exp_led;
            checks++; if (cyc !== 10) begin fails++; $display("FAIL blink_interval %0d: got %0d cycles expected 10", i, cyc); end
            checks++; if (led !== exp_led) begin fails++; $display("FAIL blink_led %0d: got %h expected %h", i, led, exp_led); end
        end
    endtask

    task automatic test_breathe();
        int cyc;
        int highs = 0;
        logic mixed = 1'b0;
        mode_sel = 2'd3;
        @(negedge clk_50mhz);
        repeat (30) @(negedge clk_50mhz);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_50mhz);
            if (led === 4'hF) highs++;
            else if (led !== 4'h0) mixed = 1'b1;
        end
        checks++; if (highs !== 3) begin fails++; $display("FAIL breathe_duty3: got %0d high cycles expected 3", highs); end
        checks++; if (mixed) begin fails++; $display("FAIL breathe_uniform: got mixed led bits expected all equal"); end
        wait_step(100, cyc);
        checks++; if (cyc !== 32) begin fails++; $display("FAIL breathe_top_reversal: got %0d cycles expected 32", cyc); end
        wait_step(100, cyc);
        checks++; if (cyc !== 70) begin fails++; $display("FAIL breathe_bottom_reversal: got %0d cycles expected 70", cyc); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_pause();
        test_scan();
        test_async_reset();
        test_blink();
        test_breathe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
